// File: rtl/period_det_pkg.sv
// ============================================================================
// Module      : period_det_pkg
// Description : Shared state encoding for the rollover period detector.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package period_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/period_det_interval_cnt.sv
// ============================================================================
// Module      : period_det_interval_cnt
// Description : Counts edges between rollover pulses and reports the interval.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module period_det_interval_cnt #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         roll_over_i,
  input  logic         hold_i,
  output logic [N-1:0] interval_o,
  output logic         overflow_o,
  output logic         pulse_o
);

  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (roll_over_i || hold_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The wrap to zero is intentional: an interval of 2^N reads back as 0.
  assign interval_o = cnt_q + 1'b1;
  assign overflow_o = !roll_over_i && !hold_i && (cnt_q == '1);
  assign pulse_o    = roll_over_i;

endmodule

`default_nettype wire

// File: rtl/rollover_period_detector.sv
// ============================================================================
// Module      : rollover_period_detector
// Description : Recovers modulus k from a rollover strobe, tracks lock/errors.
//               PERIOD_DET_STICKY_ERR_EN makes o_err hold until reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rollover_period_detector #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_roll_over,
  output logic [N-1:0] o_k,
  output logic         o_locked,
  output logic         o_err
);

  import period_det_pkg::*;

  state_t       state_q, state_d;
  logic [N-1:0] cand_q, cand_d;
  logic [N-1:0] k_q, k_d;
  logic         locked_q, locked_d;
  logic         err_q, err_d;
  logic         err_event;

  logic [N-1:0] interval;
  logic         overflow;
  logic         pulse;

  period_det_interval_cnt #(
    .N (N)
  ) u_interval_cnt (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .roll_over_i (i_roll_over),
    .hold_i      (state_q == IDLE),
    .interval_o  (interval),
    .overflow_o  (overflow),
    .pulse_o     (pulse)
  );

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    k_d       = k_q;
    locked_d  = locked_q;
    err_event = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse) state_d = FIRST;
      end
      FIRST: begin
        if (pulse) begin
          state_d = CHECK;
          cand_d  = interval;
        end else if (overflow) begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (pulse) begin
          if (interval == cand_q) begin
            state_d  = LOCKED;
            k_d      = cand_q;
            locked_d = 1'b1;
          end else begin
            cand_d = interval;
          end
        end else if (overflow) begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (pulse) begin
          if (interval != k_q) begin
            state_d   = CHECK;
            cand_d    = interval;
            locked_d  = 1'b0;
            err_event = 1'b1;
          end
        end else if (interval == k_q) begin
          // Expected pulse missing; the counter keeps running so the eventual
          // pulse still measures the true interval.
          state_d   = FIRST;
          locked_d  = 1'b0;
          err_event = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PERIOD_DET_STICKY_ERR_EN
  assign err_d = err_q | err_event;
`else
  assign err_d = err_event;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      k_q      <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      k_q      <= k_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign o_k      = k_q;
  assign o_locked = locked_q;
  assign o_err    = err_q;

endmodule

`default_nettype wire

// File: doc/rollover_period_detector.md
Name: rollover_period_detector

Overview:
- Receive side of the mod-k counter rollover interface: watches a single-bit rollover pulse stream and recovers the modulus k.
- Declares lock once two consecutive equal intervals are seen, then flags any deviation (early or late pulse).
- Sits next to any rollover-producing counter for self-check, or on a link where only the rollover strobe is transported.

Parameters:
N, 8, width of recovered k; measurable period 1..2^N cycles; period 2^N is reported as k=0, matching the generator's wrap behaviour for k=0.

Ports:
i_clk  input  1  clock; all logic on posedge.
i_reset  input  1  asynchronous, active-high reset.
i_roll_over  input  1  rollover pulse, sampled each posedge; high for one cycle per period; constant high means k=1.
o_k  output  N  recovered modulus; valid only while o_locked=1; holds last value otherwise.
o_locked  output  1  high while the pulse stream matches o_k.
o_err  output  1  mismatch indicator; see Optional Feature.

Behaviour:
- Reset (async, any state): state=IDLE, m_cnt=0, m_cand=0, o_k=0, o_locked=0, o_err=0. Reset dominates a simultaneous pulse.
- m_cnt (N bits) counts edges since the last pulse edge.
  - At a pulse edge: interval = (m_cnt+1) mod 2^N, with 0 meaning 2^N; then m_cnt<=0.
  - Otherwise m_cnt<=m_cnt+1.
- Overflow: non-pulse edge with m_cnt==2^N-1, i.e. the period would exceed 2^N.
- Example k=3, pulses on edges 3,6,9 -> each interval=3.
- States: enum IDLE, FIRST, CHECK, LOCKED.
  - IDLE: m_cnt held at 0. Pulse -> FIRST.
  - FIRST: pulse -> CHECK, m_cand<=interval. Overflow -> IDLE.
  - CHECK:
    - Pulse with interval==m_cand -> LOCKED, o_k<=m_cand, o_locked<=1.
    - Pulse with interval!=m_cand -> stay CHECK, m_cand<=interval.
    - Overflow -> IDLE.
  - LOCKED:
    - Pulse with interval==o_k -> stay LOCKED.
    - Early pulse (interval!=o_k) -> CHECK, m_cand<=interval, o_locked<=0, error event.
    - Late: non-pulse edge where (m_cnt+1) mod 2^N == o_k -> FIRST, o_locked<=0, error event. m_cnt keeps counting, so the next pulse yields a true interval.
- Outputs are registered. o_locked rises in the cycle after the third consistent pulse edge; latency = 2 periods + 1 edge after the first pulse.
- k=1, constant high: intervals 1,1 -> locked after 3 edges of high input.
- o_k updates only on entry to LOCKED.

Optional Feature:
- Macro PERIOD_DET_STICKY_ERR_EN.
- Defined: o_err sets on any error event and stays high until reset; a later relock does not clear it.
- Undefined: o_err is high exactly one cycle, the cycle after the error-event edge.
- All other behaviour is identical in both builds.

Decomposition:
- Package period_det_pkg holds typedef enum logic [1:0] state_t {IDLE, FIRST, CHECK, LOCKED}.
- One sub-module, period_det_interval_cnt (parameter N). It owns m_cnt and outputs interval, overflow flag and pulse-qualified strobe.
- The FSM, o_k/o_locked/o_err registers and the sticky logic stay in the top module.

Test Plan:
- N=8, pulses every 3 cycles from edge 3 -> o_locked=1, o_k=3 in the cycle after edge 9; o_err stays 0.
- i_roll_over held high from edge 1 -> o_locked=1, o_k=1 after edge 3. Drive by an actual generator with k=0 -> o_locked=1, o_k=0 after 2x256 cycles.
- Locked at k=5, next pulse after 4 cycles:
  - Pulse edge: o_locked 0, o_err pulses 1 cycle.
  - Intervals 4 then 4: relock with o_k=4.
  - With PERIOD_DET_STICKY_ERR_EN, o_err remains 1 after relock.
- Locked at k=5, one pulse omitted:
  - o_err and o_locked 0 at 5 cycles after the last pulse.
  - Next pulse at 10 -> CHECK, cand=10.
  - Pulses then every 10 -> locked o_k=10.
- First pulse, then no pulse for 256 edges -> state returns to IDLE, o_locked stays 0.
- Assert i_reset mid-lock, asynchronous and between edges, with a pulse on the next edge:
  - All outputs 0 immediately.
  - Relock requires 3 fresh pulses.
